// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and writeback types used by the writeback arbiter.
// Holds the register-file geometry, requester ids and a saturating counter helper.
package rv32i_pkg;

  localparam int unsigned REGF_WIDTH = 32;
  localparam int unsigned SELECTORS  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [SELECTORS-1:0]  addr;
    logic [REGF_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// master: requester/pipeline side; slave: the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned REGF_WIDTH = rv32i_pkg::REGF_WIDTH,
  parameter int unsigned SELECTORS  = rv32i_pkg::SELECTORS
);
  localparam int unsigned IdxW = $clog2(NREQ);

  logic                                  wb_stall;
  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0][SELECTORS-1:0]        req_addr;
  logic [NREQ-1:0][REGF_WIDTH-1:0]       req_data;
  logic [NREQ-1:0]                       req_ready;
  logic [SELECTORS-1:0]                  rsW;
  logic [REGF_WIDTH-1:0]                 rd;
  logic                                  RegWEn;
  logic [IdxW-1:0]                       grant_id;
  logic [NREQ-1:0]                       starve;

  modport master (
    output wb_stall, req_valid, req_addr, req_data,
    input  req_ready, rsW, rd, RegWEn, grant_id, starve
  );

  modport slave (
    input  wb_stall, req_valid, req_addr, req_data,
    output req_ready, rsW, rd, RegWEn, grant_id, starve
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Rotating priority picker: first valid requester after ptr_i, modulo NREQ.
// With ptr_i tied to NREQ-1 it is a plain lowest-index-first encoder.
module rr_pick
  import rv32i_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin : pick
    logic            found;
    logic [IdxW-1:0] cand;
    found = 1'b0;
    cand  = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!found && valid_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: one grant per cycle, registered write one cycle later.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority (index 0 first).
module regfile_wb_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned REGF_WIDTH = rv32i_pkg::REGF_WIDTH,
  parameter int unsigned SELECTORS  = rv32i_pkg::SELECTORS,
  parameter int unsigned STARVE_LIM = 7
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  import rv32i_pkg::*;

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [IdxW-1:0]       ptr;
  logic [NREQ-1:0]       gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic [NREQ-1:0]       ready;
  logic                  accept;

  logic [SELECTORS-1:0]  rsw_q, rsw_d;
  logic [REGF_WIDTH-1:0] rd_q, rd_d;
  logic                  we_q, we_d;
  logic [IdxW-1:0]       gid_q, gid_d;
  logic [NREQ-1:0]       starve_q, starve_d;
  logic [NREQ-1:0][3:0]  wait_cnt_q, wait_cnt_d;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IdxW'(NREQ - 1);
    end else if (accept) begin
      ptr_q <= gnt_idx;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = IdxW'(NREQ - 1);
`endif

  // Grants are suppressed combinationally so nothing is consumed during reset or stall.
  assign ready  = (rst || bus.wb_stall) ? '0 : gnt;
  assign accept = |ready;

  always_comb begin
    rsw_d = rsw_q;
    rd_d  = rd_q;
    gid_d = gid_q;
    we_d  = 1'b0;
    if (accept) begin
      rsw_d = bus.req_addr[gnt_idx];
      rd_d  = bus.req_data[gnt_idx];
      gid_d = gnt_idx;
      we_d  = (bus.req_addr[gnt_idx] != '0);
    end
  end

  // A grant clears the counter even when it would otherwise increment.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    starve_d   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || ready[i]) begin
        wait_cnt_d[i] = 4'd0;
      end else begin
        wait_cnt_d[i] = sat_inc4(wait_cnt_q[i]);
      end
      starve_d[i] = (32'(wait_cnt_d[i]) >= STARVE_LIM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsw_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      gid_q      <= '0;
      starve_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      rsw_q      <= rsw_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      gid_q      <= gid_d;
      starve_q   <= starve_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsW       = rsw_q;
  assign bus.rd        = rd_q;
  assign bus.RegWEn    = we_q;
  assign bus.grant_id  = gid_q;
  assign bus.starve    = starve_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_ARB_ROUND_ROBIN_EN if defined.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(3), .REGF_WIDTH(32), .SELECTORS(5)) bus ();

  regfile_wb_arbiter #(
    .NREQ       (3),
    .REGF_WIDTH (32),
    .SELECTORS  (5),
    .STARVE_LIM (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                        input logic [1:0] g, input logic we);
    chk({tag, ".rsW"}, 32'(bus.rsW), 32'(a));
    chk({tag, ".rd"}, bus.rd, d);
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(g));
    chk({tag, ".RegWEn"}, 32'(bus.RegWEn), 32'(we));
  endtask

  initial begin
    int exp_idx;
    bus.wb_stall    = 1'b0;
    bus.req_valid   = 3'b111;
    bus.req_addr[0] = 5'd1;
    bus.req_addr[1] = 5'd2;
    bus.req_addr[2] = 5'd3;
    bus.req_data[0] = 32'hA;
    bus.req_data[1] = 32'hB;
    bus.req_data[2] = 32'hC;

    // Reset state with requests pending
    #1;
    chk_wr("reset", 5'd0, 32'd0, 2'd0, 1'b0);
    chk("reset.starve", 32'(bus.starve), 32'd0);
    chk("reset.ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    chk("reset_held.ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;

    // All three valid
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_idx = k % 3;
`else
      exp_idx = 0;
`endif
      chk("arb.ready", 32'(bus.req_ready), 32'(1 << exp_idx));
      tick();
      chk_wr("arb", 5'(exp_idx + 1), 32'(32'hA + exp_idx), 2'(exp_idx), 1'b1);
    end

    // Reset mid-stream clears outputs immediately
    #3 rst = 1'b1;
    #1;
    chk_wr("midrst", 5'd0, 32'd0, 2'd0, 1'b0);
    chk("midrst.ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.ready", 32'(bus.req_ready), 32'b001);
    tick();
    chk_wr("post_rst", 5'd1, 32'hA, 2'd0, 1'b1);

    // x0 request is consumed with no write enable
    bus.req_valid   = 3'b001;
    bus.req_addr[0] = 5'd0;
    bus.req_data[0] = 32'hDEAD;
    #1;
    chk("x0.ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    #1;
    chk_wr("x0", 5'd0, 32'hDEAD, 2'd0, 1'b0);
    chk("x0.ready_after", 32'(bus.req_ready), 32'd0);
    tick();
    chk("x0.idle_we", 32'(bus.RegWEn), 32'd0);

    // Stall for three cycles with requester 1 pending
    bus.wb_stall    = 1'b1;
    bus.req_valid   = 3'b010;
    bus.req_addr[1] = 5'd2;
    bus.req_data[1] = 32'hB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("stall.we", 32'(bus.RegWEn), 32'd0);
    end
    chk("stall.wait_cnt1", 32'(dut.wait_cnt_q[1]), 32'd3);
    bus.wb_stall = 1'b0;
    #1;
    chk("unstall.ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = 3'b000;
    chk_wr("unstall", 5'd2, 32'hB, 2'd1, 1'b1);
    chk("unstall.wait_cnt1", 32'(dut.wait_cnt_q[1]), 32'd0);
    tick();

`ifndef WB_ARB_ROUND_ROBIN_EN
    // Fixed priority starves index 2
    bus.req_valid   = 3'b101;
    bus.req_addr[0] = 5'd1;
    bus.req_data[0] = 32'h11;
    bus.req_addr[2] = 5'd3;
    bus.req_data[2] = 32'h33;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("starve.ready", 32'(bus.req_ready), 32'b001);
      tick();
      chk("starve.grant_id", 32'(bus.grant_id), 32'd0);
      chk("starve.wait_cnt2", 32'(dut.wait_cnt_q[2]), 32'(k));
      chk("starve.starve", 32'(bus.starve), (k >= 7) ? 32'b100 : 32'b000);
    end
    bus.req_valid = 3'b000;
    tick();
    chk("starve.clear", 32'(bus.starve), 32'd0);
`endif

    // Back-to-back single requester
    bus.req_valid   = 3'b100;
    bus.req_addr[2] = 5'd7;
    for (int k = 1; k <= 5; k++) begin
      bus.req_data[2] = 32'(k);
      #1;
      chk("b2b.ready", 32'(bus.req_ready), 32'b100);
      tick();
      chk_wr("b2b", 5'd7, 32'(k), 2'd2, 1'b1);
    end
    bus.req_valid = 3'b000;
    tick();
    chk("b2b.idle_we", 32'(bus.RegWEn), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
